avr_io_master: RTL and testbench

//  Initiator side of the AVR I/O / data-memory peripheral bus. Accepts byte commands (read, write,
//  set-bits, clear-bits) on a valid/ready port and turns them into adr/iore/iowe or ramadr/ramre/ramwe/dm_sel

---
 rtl/avr_io_master.sv | 150 +++++++++++++++
 tb/tb_avr_io_master.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_io_master.sv
// avr_io_master: initiator for the AVR I/O / data-memory peripheral bus.
// Takes byte commands (read, write, set-bits, clear-bits) on a valid/ready
// port and turns each one into a single I/O-space (adr/iore/iowe) or DM-space
// (ramadr/ramre/ramwe/dm_sel) bus cycle. It then returns a response carrying
// the data and an error flag.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   clken               clock enable; state, counters and handshakes only advance when it is 1
//   cmd_valid/ready     command handshake
//   cmd_op              00 read, 01 write, 10 set bits, 11 clear bits
//   cmd_addr, cmd_data  data-space address; write data or bit mask
//   rsp_valid/ready     response handshake
//   rsp_data, rsp_err   read data or the value written; error flag (bad address or read timeout)
//   adr, iore, iowe     I/O-space address and strobes
//   ramadr, ramre, ramwe, dm_sel   DM-space address, strobes and select
//   dbus_out            write data to the responders
//   dbus_in, io_out_en  OR-ed read data from the responders, and its qualifier
module avr_io_master #(
  parameter int unsigned TIMEOUT = 4,
  parameter logic [7:0]  IO_BASE = 8'h20,
  parameter logic [7:0]  DM_BASE = 8'h60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [5:0] adr,
  output logic       iore,
  output logic       iowe,
  output logic [7:0] ramadr,
  output logic       ramre,
  output logic       ramwe,
  output logic       dm_sel,
  output logic [7:0] dbus_out,
  input  logic [7:0] dbus_in,
  input  logic       io_out_en
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t     state, state_nx;
  logic [1:0] op_q;
  logic [7:0] data_q;
  logic [7:0] rd_q;
  logic [7:0] wait_q;
  logic [5:0] adr_q;
  logic [7:0] ramadr_q;
  logic       dm_q;
  logic [7:0] wr_val;
  logic       accept, bad_addr, in_rd, in_wr, rd_done, rd_tmo;

  always_comb begin
    state_nx  = state;
    cmd_ready = (state == IDLE) && !rst;
    accept    = cmd_valid && cmd_ready && clken;
    bad_addr  = cmd_addr < IO_BASE;
    in_rd     = (state == RD);
    in_wr     = (state == WR);
    rd_done   = in_rd && clken && io_out_en;
    // The last permitted wait cycle is the one where wait_q reaches TIMEOUT-1.
    rd_tmo    = in_rd && clken && !io_out_en && (wait_q == 8'(TIMEOUT - 1));

    case (op_q)
      2'b10:   wr_val = rd_q | data_q;
      2'b11:   wr_val = rd_q & ~data_q;
      default: wr_val = data_q;
    endcase

    case (state)
      IDLE: begin
        if (accept) begin
          if (bad_addr)              state_nx = RSP;
          else if (cmd_op == 2'b01)  state_nx = WR;
          else                       state_nx = RD;
        end
      end
      RD: begin
        if (rd_done)     state_nx = (op_q == 2'b00) ? RSP : WR;
        else if (rd_tmo) state_nx = RSP;
      end
      WR:      if (clken) state_nx = RSP;
      RSP:     if (clken && rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    rsp_valid = (state == RSP);
    iore      = in_rd && !dm_q;
    ramre     = in_rd && dm_q;
    iowe      = in_wr && !dm_q;
    ramwe     = in_wr && dm_q;
    dm_sel    = ramre || ramwe;
    adr       = (iore || iowe) ? adr_q : '0;
    ramadr    = dm_sel ? ramadr_q : '0;
    dbus_out  = in_wr ? wr_val : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      data_q   <= '0;
      rd_q     <= '0;
      wait_q   <= '0;
      adr_q    <= '0;
      ramadr_q <= '0;
      dm_q     <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q     <= cmd_op;
        data_q   <= cmd_data;
        adr_q    <= 6'(cmd_addr - IO_BASE);
        ramadr_q <= cmd_addr;
        dm_q     <= (cmd_addr >= DM_BASE);
        wait_q   <= '0;
        if (bad_addr) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
      // On an RMW, rsp_data holds the read value only briefly; WR overwrites it before RSP.
      if (rd_done) begin
        rd_q     <= dbus_in;
        rsp_data <= dbus_in;
        rsp_err  <= 1'b0;
      end else if (rd_tmo) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end else if (in_rd && clken) begin
        wait_q <= wait_q + 8'd1;
      end
      if (in_wr && clken) begin
        rsp_data <= wr_val;
        rsp_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_avr_io_master.sv
// Testbench for avr_io_master. A bench responder serves reads after a
// programmable number of clken cycles and stores writes. A command-level
// reference model predicts the response, the strobe counts and the written
// value for every command.
module tb_avr_io_master;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       rst, clken, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0] cmd_op;
  logic [7:0] cmd_addr, cmd_data, rsp_data, ramadr, dbus_out, dbus_in;
  logic [5:0] adr;
  logic       iore, iowe, ramre, ramwe, dm_sel, io_out_en;

  always #5 clk = ~clk;

  avr_io_master #(.TIMEOUT(TO), .IO_BASE(8'h20), .DM_BASE(8'h60)) dut (
    .clk(clk), .rst(rst), .clken(clken),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .adr(adr), .iore(iore), .iowe(iowe),
    .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe), .dm_sel(dm_sel),
    .dbus_out(dbus_out), .dbus_in(dbus_in), .io_out_en(io_out_en)
  );

  // ---------------- responder ----------------
  logic [7:0]  io_mem [64]  = '{default: 8'h00};
  logic [7:0]  dm_mem [256] = '{default: 8'h00};
  int unsigned rd_seen    = 0;
  int unsigned resp_delay = 0;

  always @(posedge clk) begin
    if (clken && iowe)  io_mem[adr]    <= dbus_out;
    if (clken && ramwe) dm_mem[ramadr] <= dbus_out;
    if (!(iore || ramre))           rd_seen <= 0;
    else if (clken && !io_out_en)   rd_seen <= rd_seen + 1;
  end

  assign io_out_en = (iore || ramre) && (rd_seen >= resp_delay);
  assign dbus_in   = io_out_en ? (ramre ? dm_mem[ramadr] : io_mem[adr]) : 8'hEE;

  // ---------------- monitor ----------------
  int unsigned io_rd_n = 0, dm_rd_n = 0, io_wr_n = 0, dm_wr_n = 0, viol = 0;
  logic [7:0]  last_wval = 8'h00, last_wadr = 8'h00;

  always @(negedge clk) begin
    if (clken === 1'b1) begin
      if (iore)  io_rd_n <= io_rd_n + 1;
      if (ramre) dm_rd_n <= dm_rd_n + 1;
      if (iowe) begin
        io_wr_n <= io_wr_n + 1; last_wval <= dbus_out; last_wadr <= {2'b00, adr};
      end
      if (ramwe) begin
        dm_wr_n <= dm_wr_n + 1; last_wval <= dbus_out; last_wadr <= ramadr;
      end
    end
    if (int'(iore) + int'(iowe) + int'(ramre) + int'(ramwe) > 1) begin
      viol <= viol + 1;
      $display("FAIL strobe_onehot: got iore=%b iowe=%b ramre=%b ramwe=%b, need at most one", iore, iowe, ramre, ramwe);
    end
    if (dm_sel !== (ramre | ramwe)) begin
      viol <= viol + 1;
      $display("FAIL dm_sel: got %b need %b", dm_sel, ramre | ramwe);
    end
    if ((!(iore || iowe) && adr !== 6'h00) || (!(ramre || ramwe) && ramadr !== 8'h00) ||
        (!(iowe || ramwe) && dbus_out !== 8'h00)) begin
      viol <= viol + 1;
      $display("FAIL idle_bus: got adr=%h ramadr=%h dbus_out=%h, need 0 outside cycles", adr, ramadr, dbus_out);
    end
  end

  // ---------------- driver / reference model ----------------
  int          n_cmp = 0, n_bad = 0;
  int          clk_mode = 0;
  int unsigned cyc = 0;
  logic [7:0]  ref_io [64]  = '{default: 8'h00};
  logic [7:0]  ref_dm [256] = '{default: 8'h00};

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    case (clk_mode)
      0:       clken = 1'b1;
      1:       clken = (cyc % 4 == 0);
      default: clken = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                         input int unsigned dly, input int unsigned hold,
                         output logic [7:0] got_d, output logic got_e);
    logic        bad, dm, exp_e, stable;
    logic [7:0]  off, cur, exp_d, hd;
    logic        he;
    int unsigned exp_rd, exp_wr, exp_lat, k;
    int unsigned s_ir, s_dr, s_iw, s_dw;
    bad    = (a < 8'h20);
    dm     = (a >= 8'h60);
    off    = dm ? a : a - 8'h20;
    cur    = dm ? ref_dm[off] : ref_io[off[5:0]];
    exp_rd = 0; exp_wr = 0; exp_e = 1'b0; exp_d = 8'h00; exp_lat = 2;
    if (bad) begin
      exp_e = 1'b1; exp_lat = 1;
    end else begin
      if (op != 2'b01) begin
        if (dly >= TO) begin exp_rd = TO; exp_e = 1'b1; exp_lat = TO + 1; end
        else begin exp_rd = dly + 1; exp_lat = dly + 2; end
      end
      if (!exp_e) begin
        case (op)
          2'b00:   exp_d = cur;
          2'b01:   exp_d = d;
          2'b10:   exp_d = cur | d;
          default: exp_d = cur & ~d;
        endcase
        if (op != 2'b00) begin
          exp_wr = 1;
          if (op != 2'b01) exp_lat++;
          if (dm) ref_dm[off] = exp_d; else ref_io[off[5:0]] = exp_d;
        end
      end
    end
    s_ir = io_rd_n; s_dr = dm_rd_n; s_iw = io_wr_n; s_dw = dm_wr_n;
    got_d = 8'h00; got_e = 1'b0;
    resp_delay = dly;
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1; rsp_ready = 1'b0;
    k = 0;
    while (!(cmd_ready && clken) && k < 200) begin tick; k++; end
    if (k >= 200) begin
      n_cmp++; n_bad++; cmd_valid = 1'b0;
      $display("FAIL accept_timeout: got cmd_ready=%b, need 1 within 200 cycles", cmd_ready);
      return;
    end
    tick;
    cmd_valid = 1'b0; cmd_addr = 8'($urandom); cmd_data = 8'($urandom); cmd_op = 2'($urandom);
    k = 1;
    while (!rsp_valid && k < 300) begin tick; k++; end
    n_cmp++;
    if (!rsp_valid) begin
      n_bad++;
      $display("FAIL rsp_timeout: got rsp_valid=%b, need 1 within 300 cycles", rsp_valid);
      return;
    end
    if (clk_mode == 0) begin
      n_cmp++;
      if (k != exp_lat) begin n_bad++; $display("FAIL latency a=%h op=%0d: got %0d need %0d", a, op, k, exp_lat); end
    end
    got_d = rsp_data; got_e = rsp_err;
    n_cmp++;
    if (rsp_data !== exp_d || rsp_err !== exp_e) begin
      n_bad++;
      $display("FAIL rsp a=%h op=%0d d=%h: got data=%h err=%b need data=%h err=%b", a, op, d, rsp_data, rsp_err, exp_d, exp_e);
    end
    hd = rsp_data; he = rsp_err; stable = 1'b1;
    for (int i = 0; i < int'(hold); i++) begin
      tick;
      if (rsp_valid !== 1'b1 || rsp_data !== hd || rsp_err !== he) stable = 1'b0;
    end
    if (hold > 0) begin
      n_cmp++;
      if (!stable) begin n_bad++; $display("FAIL rsp_stable: got changed rsp while held, need valid=1 data=%h err=%b", hd, he); end
    end
    rsp_ready = 1'b1;
    k = 0;
    while (!(rsp_valid && clken) && k < 200) begin tick; k++; end
    tick;
    rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL rsp_taken: got rsp_valid=%b cmd_ready=%b need 0/1", rsp_valid, cmd_ready);
    end
    n_cmp++;
    if ((io_rd_n - s_ir) != (dm ? 0 : exp_rd) || (dm_rd_n - s_dr) != (dm ? exp_rd : 0)) begin
      n_bad++;
      $display("FAIL read_strobes a=%h: got io=%0d dm=%0d need %0d in %s space", a, io_rd_n - s_ir, dm_rd_n - s_dr, exp_rd, dm ? "dm" : "io");
    end
    n_cmp++;
    if ((io_wr_n - s_iw) != (dm ? 0 : exp_wr) || (dm_wr_n - s_dw) != (dm ? exp_wr : 0)) begin
      n_bad++;
      $display("FAIL write_strobes a=%h: got io=%0d dm=%0d need %0d in %s space", a, io_wr_n - s_iw, dm_wr_n - s_dw, exp_wr, dm ? "dm" : "io");
    end
    if (exp_wr == 1) begin
      n_cmp++;
      if (last_wval !== exp_d || last_wadr !== (dm ? a : off)) begin
        n_bad++;
        $display("FAIL write_value: got adr=%h val=%h need adr=%h val=%h", last_wadr, last_wval, dm ? a : off, exp_d);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_op = 2'b00; cmd_addr = 8'h00; cmd_data = 8'h00;
    clken = 1'b0;
    repeat (3) begin @(posedge clk); #1; clken = 1'b0; end
    n_cmp++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 8'h00) begin
      n_bad++; $display("FAIL reset_handshake: got ready=%b valid=%b err=%b data=%h need 0", cmd_ready, rsp_valid, rsp_err, rsp_data);
    end
    n_cmp++;
    if ({iore, iowe, ramre, ramwe, dm_sel} !== 5'b0 || adr !== 6'h00 || ramadr !== 8'h00 || dbus_out !== 8'h00) begin
      n_bad++; $display("FAIL reset_bus: got strobes=%b adr=%h ramadr=%h dbus=%h need 0",
                        {iore, iowe, ramre, ramwe, dm_sel}, adr, ramadr, dbus_out);
    end
    rst = 1'b0;
    tick;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b need 1", cmd_ready); end
  endtask

  task automatic test_write_io;
    logic [7:0] d; logic e;
    run_cmd(2'b01, 8'h25, 8'hA5, 0, 0, d, e);
    n_cmp++;
    if (d !== 8'hA5 || e !== 1'b0 || last_wadr !== 8'h05 || last_wval !== 8'hA5) begin
      n_bad++; $display("FAIL write_io: got data=%h err=%b adr=%h val=%h need A5/0/05/A5", d, e, last_wadr, last_wval);
    end
  endtask

  task automatic test_read_io;
    logic [7:0] d; logic e;
    run_cmd(2'b01, 8'h23, 8'h3C, 0, 0, d, e);
    run_cmd(2'b00, 8'h23, 8'h00, 0, 0, d, e);
    n_cmp++;
    if (d !== 8'h3C || e !== 1'b0) begin n_bad++; $display("FAIL read_io: got %h/%b need 3C/0", d, e); end
  endtask

  task automatic test_rmw;
    logic [7:0] d; logic e;
    run_cmd(2'b01, 8'h2B, 8'h10, 0, 0, d, e);
    run_cmd(2'b10, 8'h2B, 8'h81, 0, 0, d, e);
    n_cmp++;
    if (d !== 8'h91 || last_wval !== 8'h91) begin n_bad++; $display("FAIL set_bits: got rsp=%h bus=%h need 91", d, last_wval); end
    run_cmd(2'b11, 8'h2B, 8'h10, 1, 0, d, e);
    n_cmp++;
    if (d !== 8'h81 || last_wval !== 8'h81) begin n_bad++; $display("FAIL clear_bits: got rsp=%h bus=%h need 81", d, last_wval); end
  endtask

  task automatic test_dm_and_bad;
    logic [7:0] d; logic e;
    int unsigned total;
    run_cmd(2'b01, 8'h7A, 8'h5A, 0, 0, d, e);
    n_cmp++;
    if (last_wadr !== 8'h7A || d !== 8'h5A) begin n_bad++; $display("FAIL dm_write: got adr=%h data=%h need 7A/5A", last_wadr, d); end
    total = io_rd_n + dm_rd_n + io_wr_n + dm_wr_n;
    run_cmd(2'b00, 8'h10, 8'h00, 0, 0, d, e);
    n_cmp++;
    if (d !== 8'h00 || e !== 1'b1 || (io_rd_n + dm_rd_n + io_wr_n + dm_wr_n) != total) begin
      n_bad++; $display("FAIL bad_addr: got data=%h err=%b strobes=%0d need 00/1/0", d, e, io_rd_n + dm_rd_n + io_wr_n + dm_wr_n - total);
    end
  endtask

  task automatic test_timeout;
    logic [7:0] d; logic e;
    int unsigned s;
    s = io_rd_n;
    run_cmd(2'b00, 8'h30, 8'h00, 255, 0, d, e);
    n_cmp++;
    if (io_rd_n - s != 4 || d !== 8'h00 || e !== 1'b1) begin
      n_bad++; $display("FAIL timeout: got iore=%0d data=%h err=%b need 4/00/1", io_rd_n - s, d, e);
    end
  endtask

  task automatic test_clken_backpressure;
    logic [7:0] d; logic e;
    clk_mode = 1;
    run_cmd(2'b10, 8'h2B, 8'h06, 1, 5, d, e);
    n_cmp++;
    if (d !== 8'h87 || e !== 1'b0) begin n_bad++; $display("FAIL slow_set: got %h/%b need 87/0", d, e); end
    run_cmd(2'b00, 8'h31, 8'h00, 255, 5, d, e);
    run_cmd(2'b01, 8'h90, 8'hC3, 0, 5, d, e);
    clk_mode = 0;
    clken = 1'b1;
  endtask

  task automatic test_reset_mid;
    int k;
    logic seen;
    resp_delay = 255;
    cmd_op = 2'b00; cmd_addr = 8'h40; cmd_data = 8'h00; cmd_valid = 1'b1;
    k = 0;
    while (!(cmd_ready && clken) && k < 50) begin tick; k++; end
    tick;
    cmd_valid = 1'b0;
    tick;
    n_cmp++;
    if (iore !== 1'b1) begin n_bad++; $display("FAIL rd_before_rst: got iore=%b need 1", iore); end
    rst = 1'b1;
    clken = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (iore !== 1'b0 || rsp_valid !== 1'b0 || adr !== 6'h00) begin
      n_bad++; $display("FAIL rst_mid: got iore=%b rsp_valid=%b adr=%h need 0", iore, rsp_valid, adr);
    end
    rst = 1'b0;
    seen = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) begin tick; if (rsp_valid !== 1'b0 || iore !== 1'b0) seen = 1'b1; end
    rsp_ready = 1'b0;
    n_cmp++;
    if (seen || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL no_rsp_after_rst: got activity=%b ready=%b need 0/1", seen, cmd_ready); end
  endtask

  task automatic test_random;
    logic [7:0] d; logic e;
    for (int i = 0; i < 60; i++) begin
      clk_mode = (i % 3 == 0) ? 2 : 0;
      run_cmd(2'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 5), $urandom_range(0, 3), d, e);
    end
    clk_mode = 0;
  endtask

  task automatic test_invariants;
    n_cmp++;
    if (viol != 0) begin n_bad++; $display("FAIL bus_invariants: got %0d violations need 0", viol); end
  endtask

  initial begin
    test_reset;
    test_write_io;
    test_read_io;
    test_rmw;
    test_dm_and_bad;
    test_timeout;
    test_clken_backpressure;
    test_reset_mid;
    test_random;
    repeat (2) tick;
    test_invariants;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
